harris_window_gen: RTL and testbench

//  Streaming window generator directly upstream of the Sobel gradient stage. Accepts a

---
 rtl/harris_window_gen.sv | 104 ++++++++++
 tb/tb_harris_window_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/harris_window_gen.sv
// Streaming WIN x WIN window generator feeding the Sobel/Harris pipeline.
// Buffers WIN-1 image lines and emits one full window per accepted pixel.
`timescale 1ns/1ps
module harris_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int WIN   = 6,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [WIN*WIN*PIX_W-1:0] window,
  output logic                     win_valid,
  output logic [15:0]              win_row,
  output logic [15:0]              win_col,
  output logic [15:0]              win_count,
  output logic                     frame_done
);

  localparam int          AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] COL_MAX = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_MAX = 16'(IMG_H - 1);
  localparam logic [15:0] EDGE    = 16'(WIN - 1);

  logic [15:0]      col, row, cnt;
  logic [PIX_W-1:0] lb       [WIN-1][IMG_W];
  logic [PIX_W-1:0] sr       [WIN][WIN];
  logic [PIX_W-1:0] next_sr  [WIN][WIN];
  logic [PIX_W-1:0] col_data [WIN];
  logic [WIN*WIN*PIX_W-1:0] win_flat;
  logic [15:0]      eff_col, eff_row, cnt_base;
  logic [AW-1:0]    col_a;
  logic             sof_v, gate, at_end;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sof_v    = sof & pix_valid;
    eff_col  = sof_v ? 16'd0 : col;
    eff_row  = sof_v ? 16'd0 : row;
    cnt_base = sof_v ? 16'd0 : cnt;
    col_a    = eff_col[AW-1:0];
    gate     = pix_valid && (eff_row >= EDGE) && (eff_col >= EDGE);
    at_end   = (eff_row == ROW_MAX) && (eff_col == COL_MAX);
    win_flat = '0;
    // Column entering the window: buffered lines oldest first, live pixel at the bottom.
    for (int r = 0; r < WIN - 1; r++) col_data[r] = lb[r][col_a];
    col_data[WIN-1] = pix_in;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) next_sr[r][c] = sr[r][c+1];
      next_sr[r][WIN-1] = col_data[r];
    end
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        win_flat[(r*WIN+c)*PIX_W +: PIX_W] = next_sr[r][c];
  end

  // NOTE: line-buffer RAM has no reset; stale contents are never exposed because
  // a window is only emitted after WIN-1 fresh lines have been written.
  always_ff @(posedge clk) begin
    if (pix_valid)
      for (int r = 0; r < WIN - 1; r++) lb[r][col_a] <= col_data[r+1];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      cnt        <= '0;
      window     <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_count  <= '0;
      frame_done <= 1'b0;
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) sr[r][c] <= '0;
    end else begin
      win_valid  <= gate;
      frame_done <= gate && at_end;
      if (pix_valid) begin
        sr <= next_sr;
        if (eff_col == COL_MAX) begin
          col <= '0;
          row <= (eff_row == ROW_MAX) ? 16'd0 : eff_row + 16'd1;
        end else begin
          col <= eff_col + 16'd1;
          row <= eff_row;
        end
        cnt <= gate ? cnt_base + 16'd1 : cnt_base;
      end
      if (gate) begin
        window    <= win_flat;
        win_row   <= eff_row - EDGE;
        win_col   <= eff_col - EDGE;
        win_count <= cnt_base + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_harris_window_gen.sv
// Self-checking bench for harris_window_gen: an 8x8 and a 64x64 instance share one
// pixel stream; a frame-array reference model predicts every window.
`timescale 1ns/1ps
module tb_harris_window_gen;
  localparam int WIN   = 6;
  localparam int PIX_W = 8;
  localparam int WW    = WIN * WIN * PIX_W;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    pix_in;
  logic          pix_valid, sof;
  logic [WW-1:0] window_s, window_l;
  logic          wv_s, wv_l, fd_s, fd_l;
  logic [15:0]   row_s, col_s, cnt_s, row_l, col_l, cnt_l;

  always #5 clk = ~clk;

  harris_window_gen #(.IMG_W(8), .IMG_H(8), .WIN(WIN), .PIX_W(PIX_W)) dut_s (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .window(window_s), .win_valid(wv_s), .win_row(row_s), .win_col(col_s),
    .win_count(cnt_s), .frame_done(fd_s));

  harris_window_gen #(.IMG_W(64), .IMG_H(64), .WIN(WIN), .PIX_W(PIX_W)) dut_l (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .window(window_l), .win_valid(wv_l), .win_row(row_l), .win_col(col_l),
    .win_count(cnt_l), .frame_done(fd_l));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [WW-1:0] win;
    logic [15:0]   row, col, cnt;
    logic          fd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] img [64][64];
  logic       sel;
  int         cur_w, cur_h, mr, mc, mcnt;

  // Observed-window statistics for the scenario checks.
  int            seen, fd_seen;
  logic [WW-1:0] first_win, tenth_win;
  logic [15:0]   first_row, first_col, first_cnt, tenth_cnt, last_row, last_col, last_cnt;
  logic          last_fd;

  logic [WW-1:0] m_win;
  logic          m_valid, m_fd;
  logic [15:0]   m_row, m_col, m_cnt;
  always_comb begin
    m_win   = sel ? window_l : window_s;
    m_valid = sel ? wv_l : wv_s;
    m_fd    = sel ? fd_l : fd_s;
    m_row   = sel ? row_l : row_s;
    m_col   = sel ? col_l : col_s;
    m_cnt   = sel ? cnt_l : cnt_s;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid) begin
        if (exp_q.size() == 0) check("extra_window", m_valid, '0);
        else begin
          mon_e = exp_q.pop_front();
          check("win_data", m_win, mon_e.win);
          check("win_row", m_row, mon_e.row);
          check("win_col", m_col, mon_e.col);
          check("win_count", m_cnt, mon_e.cnt);
          check("frame_done", m_fd, mon_e.fd);
        end
        if (seen == 0) begin
          first_win = m_win; first_row = m_row; first_col = m_col; first_cnt = m_cnt;
        end
        if (seen == 9) begin
          tenth_win = m_win; tenth_cnt = m_cnt;
        end
        seen++;
        last_row = m_row; last_col = m_col; last_cnt = m_cnt; last_fd = m_fd;
        if (m_fd) fd_seen++;
      end else if (m_fd) begin
        check("fd_without_valid", m_fd, '0);
      end
    end
  end

  // Reference model: the frame as a 2-D array; a window is the WIN x WIN block ending here.
  task automatic model_pix(input logic [7:0] p, input logic s);
    exp_t e;
    if (s) begin mr = 0; mc = 0; mcnt = 0; end
    img[mr][mc] = p;
    if (mr >= WIN - 1 && mc >= WIN - 1) begin
      mcnt++;
      e.win = '0;
      for (int i = 0; i < WIN; i++)
        for (int j = 0; j < WIN; j++)
          e.win[(i*WIN+j)*PIX_W +: PIX_W] = img[mr-WIN+1+i][mc-WIN+1+j];
      e.row = 16'(mr - (WIN - 1));
      e.col = 16'(mc - (WIN - 1));
      e.cnt = 16'(mcnt);
      e.fd  = (mr == cur_h - 1) && (mc == cur_w - 1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == cur_w) begin
      mc = 0;
      mr++;
      if (mr == cur_h) mr = 0;
    end
  endtask

  task automatic send(input logic [7:0] p, input logic s, input int gap_pct);
    while (int'($urandom_range(99)) < gap_pct) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_in    = 8'($urandom);
      sof       = 1'($urandom);
    end
    @(negedge clk);
    pix_in    = p;
    sof       = s;
    pix_valid = 1'b1;
    model_pix(p, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'b0;
    end
  endtask

  task automatic frame_ramp(input int off, input int gap_pct);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        send(8'((r * 8 + c + off) % 256), (r == 0 && c == 0), gap_pct);
  endtask

  task automatic clear_stats();
    seen = 0; fd_seen = 0;
    first_win = '0; tenth_win = '0;
    first_row = '0; first_col = '0; first_cnt = '0; tenth_cnt = '0;
    last_row = '0; last_col = '0; last_cnt = '0; last_fd = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, m_valid, '0);
    check({tag, "_window"}, m_win, '0);
    check({tag, "_row"}, m_row, '0);
    check({tag, "_col"}, m_col, '0);
    check({tag, "_count"}, m_cnt, '0);
    check({tag, "_fd"}, m_fd, '0);
  endtask

  task automatic check_ramp_frame(input string tag);
    check({tag, "_w00"}, first_win[0 +: 8], 8'd0);
    check({tag, "_w55"}, first_win[35*8 +: 8], 8'd45);
    check({tag, "_w05"}, first_win[5*8 +: 8], 8'd5);
    check({tag, "_first_pos"}, {first_row, first_col}, '0);
    check({tag, "_first_cnt"}, first_cnt, 16'd1);
    check({tag, "_n_windows"}, seen, 9);
    check({tag, "_last_pos"}, {last_row, last_col}, {16'd2, 16'd2});
    check({tag, "_last_cnt"}, last_cnt, 16'd9);
    check({tag, "_last_fd"}, last_fd, 1'b1);
    check({tag, "_fd_count"}, fd_seen, 1);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; cur_w = 8; cur_h = 8; mr = 0; mc = 0; mcnt = 0;
    reset = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    clear_stats();
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: gapless 8x8 ramp
    clear_stats();
    frame_ramp(0, 0);
    idle(3);
    check_ramp_frame("t1");

    // 2: same frame with ~50% valid gaps
    clear_stats();
    frame_ramp(0, 50);
    idle(3);
    check_ramp_frame("t2");

    // 3: back-to-back frames, second offset by 100
    clear_stats();
    frame_ramp(0, 0);
    frame_ramp(100, 0);
    idle(3);
    check("t3_n_windows", seen, 18);
    check("t3_f2_w00", tenth_win[0 +: 8], 8'd100);
    check("t3_f2_cnt", tenth_cnt, 16'd1);
    check("t3_fd_count", fd_seen, 2);
    check("t3_pending", exp_q.size(), 0);

    // 4: sof resync at (3,2) of a partial frame
    clear_stats();
    for (int i = 0; i < 26; i++) send(8'(200 + i), (i == 0), 0);
    frame_ramp(0, 0);
    idle(3);
    check_ramp_frame("t4");

    // 5: asynchronous reset after the fourth window, then a fresh frame
    clear_stats();
    for (int i = 0; i < 64; i++) begin
      send(8'(i), (i == 0), 0);
      if (seen >= 4) break;
    end
    idle(2);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    exp_q.delete();
    mr = 0; mc = 0; mcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    frame_ramp(0, 0);
    idle(3);
    check_ramp_frame("t5");

    // 6: default 64x64 frame of random pixels
    @(negedge clk);
    reset = 1'b1;
    sel = 1'b1; cur_w = 64; cur_h = 64; mr = 0; mc = 0; mcnt = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        send(8'($urandom), (r == 0 && c == 0), 10);
    idle(3);
    check("t6_n_windows", seen, 3481);
    check("t6_last_cnt", last_cnt, 16'd3481);
    check("t6_last_pos", {last_row, last_col}, {16'd58, 16'd58});
    check("t6_fd_count", fd_seen, 1);
    check("t6_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
